// File: rtl/blinker_pkg.sv
// Shared definitions for the multi-channel blinker.
//   ch_state_e : per-channel state encoding (ST_IDLE = 0, ST_RUN = 1)
//   DEF_PERIOD : default blink period in ticks
//   DEF_ON     : default on-time in ticks
package blinker_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    localparam int DEF_PERIOD = 8;
    localparam int DEF_ON     = 4;

endpackage

// File: rtl/blink_tick_gen.sv
// Prescaler producing the blink tick strobe.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset, clears the prescaler
//   tick    : high for one clk every PRESCALE clks (constantly high when PRESCALE = 1)
module blink_tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        tick  = (cnt_q == LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_blinker.sv
// NUM_CH independent blink channels with programmable period/on-time and a
// hazard mode that phase-locks every channel.
//   clk           : system clock, rising edge
//   reset_n       : asynchronous active-low reset
//   enable        : per-channel blink request (level)
//   hazard        : force all channels to blink in phase
//   period        : blink period in ticks (0 behaves as 1)
//   on_time       : ticks the output is high per period
//   blink_out     : registered blink outputs
//   cycle_done    : one-clk pulse when a channel's counter wraps
//   hazard_active : registered hazard mode state
module multi_blinker
    import blinker_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] enable,
    input  logic              hazard,
    input  logic [CNT_W-1:0]  period,
    input  logic [CNT_W-1:0]  on_time,
    output logic [NUM_CH-1:0] blink_out,
    output logic [NUM_CH-1:0] cycle_done,
    output logic              hazard_active
);

    logic             tick;
    logic             hazard_active_d, hazard_active_q;
    logic             hazard_prev_d, hazard_prev_q;
    logic             restart;
    logic [CNT_W-1:0] last_cnt;

    blink_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    always_comb begin
        hazard_active_d = hazard;
        hazard_prev_d   = hazard_active_q;
        // A change of the registered hazard state is seen one edge later and
        // restarts every channel in phase.
        restart         = hazard_active_q ^ hazard_prev_q;
        // Wrap point; period 0 behaves as period 1.
        last_cnt        = (period == '0) ? '0 : period - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hazard_active_q <= 1'b0;
            hazard_prev_q   <= 1'b0;
        end else begin
            hazard_active_q <= hazard_active_d;
            hazard_prev_q   <= hazard_prev_d;
        end
    end

    assign hazard_active = hazard_active_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_e        state_d, state_q;
        logic [CNT_W-1:0] count_d, count_q;
        logic             out_d, out_q;
        logic             done_d, done_q;
        logic             go;

        always_comb begin
            go      = hazard_active_q | enable[i];
            state_d = state_q;
            count_d = count_q;
            out_d   = out_q;
            done_d  = 1'b0;
            // Restart outranks a same-cycle wrap, so cycle_done stays low.
            if (restart) begin
                state_d = go ? ST_RUN : ST_IDLE;
                count_d = '0;
                out_d   = go && (on_time != '0);
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (go) begin
                            state_d = ST_RUN;
                            count_d = '0;
                            out_d   = (on_time != '0);
                        end else begin
                            out_d   = 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (!go) begin
                            state_d = ST_IDLE;
                            count_d = '0;
                            out_d   = 1'b0;
                        end else if (tick) begin
                            // >= lets a shrunken period wrap immediately.
                            if (count_q >= last_cnt) begin
                                count_d = '0;
                                done_d  = 1'b1;
                            end else begin
                                count_d = count_q + CNT_W'(1);
                            end
                            out_d = (count_d < on_time);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        count_d = '0;
                        out_d   = 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ST_IDLE;
                count_q <= '0;
                out_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                count_q <= count_d;
                out_q   <= out_d;
                done_q  <= done_d;
            end
        end

        assign blink_out[i]  = out_q;
        assign cycle_done[i] = done_q;
    end

endmodule
